ipsxb_fft_pattern_gen: RTL and testbench
========================================

IPSXB_FFT_PATTERN_GEN -- requirements
Module: ipsxb_fft_pattern_gen

Interface
REQ-001 SHALL have parameter CLKDIV, default 2: clock-enable divide ratio; 1 means o_aclken tied high.
REQ-002 SHALL have parameter INPUT_WIDTH, default 16: sample width per component; DW = 8*ceil(INPUT_WIDTH/8).
REQ-003 SHALL have parameter MAX_LOG2_LEN, default 12: largest supported log2 FFT length; LW = clog2(MAX_LOG2_LEN+1).
REQ-004 SHALL have parameter FRM_NUM_WIDTH, default 8: width of frame-count input and counter.
REQ-005 SHALL have parameter GAP_WIDTH, default 8: width of inter-frame gap input.
REQ-006 Ports, clock and reset first:
- i_aclk  in  1  sole clock.
- i_aresetn  in  1  asynchronous reset, active low.
- o_aclken  out  1  clock enable; all state advances only when high.
- i_start  in  1  start pulse; sampled when o_aclken high.
- i_abort  in  1  stop request; level-sampled.
- i_log2_len  in  LW  log2 frame length.
- i_pattern  in  2  0 LFSR, 1 ramp, 2 impulse, 3 constant.
- i_mode  in  2  0 FFT only, 1 IFFT only, 2 alternate starting FFT, 3 = 2.
- i_frm_num  in  FRM_NUM_WIDTH  frames per run; 0 treated as 1.
- i_gap  in  GAP_WIDTH  idle enabled-cycles between frames.
- i_axi4s_data_tready  in  1  sink ready.
- o_axi4s_data_tvalid  out  1  sample valid.
- o_axi4s_data_tdata  out  2*DW  {im, re}, each sign-extended to DW.
- o_axi4s_data_tlast  out  1  last sample of frame.
- o_axi4s_cfg_tvalid  out  1  config valid.
- o_axi4s_cfg_tdata  out  1  1 = FFT, 0 = IFFT.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-enabled-cycle pulse at normal run completion.
- o_frm_cnt  out  FRM_NUM_WIDTH  frames fully transferred this run.

Function
REQ-007 Divider SHALL assert o_aclken one cycle in every CLKDIV cycles; first assertion on the CLKDIV-th cycle after reset release.
REQ-008 States SHALL be IDLE, CFG, SEND, GAP, DONE.
REQ-009 IDLE -> CFG on i_start; i_log2_len, i_pattern, i_mode, i_frm_num, i_gap SHALL be latched then and held for the run. i_start outside IDLE SHALL be ignored.
REQ-010 Latched log2 length SHALL be clamped to [3, MAX_LOG2_LEN]; N = 2^clamped.
REQ-011 CFG SHALL assert o_axi4s_cfg_tvalid for exactly one enabled cycle, then enter SEND; cfg_tdata SHALL be the direction of the upcoming frame and stay stable until the next CFG.
REQ-012 Direction: mode 0 always 1; mode 1 always 0; mode 2/3 is 1 for frame 0, then toggles each frame.
REQ-013 SEND SHALL assert tvalid; tdata and tlast SHALL hold stable until the enabled cycle where tready is high; a beat transfers only then.
REQ-014 Sample index k SHALL run 0..N-1 within a frame; tlast SHALL be high exactly when k = N-1.
REQ-015 Pattern 0: re seed 1, im seed all ones except LSB 0; each transfer next = {x[W-2:0], x[W-1]^x[0]}; both reseed at every frame start.
REQ-016 Pattern 1: re = k zero-extended or truncated to INPUT_WIDTH; im = bitwise NOT re.
REQ-017 Pattern 2: re = 1 at k = 0 else 0; im = 0.
REQ-018 Pattern 3: re = 2^(INPUT_WIDTH-2); im = 0.
REQ-019 On the tlast transfer o_frm_cnt SHALL increment; if it equals effective frame count, go to DONE; else to GAP if latched gap > 0, otherwise CFG.
REQ-020 GAP SHALL hold tvalid low for exactly latched-gap enabled cycles, then enter CFG.
REQ-021 DONE SHALL pulse o_done for one enabled cycle, then return to IDLE; o_frm_cnt SHALL hold until the next i_start clears it.
REQ-022 i_abort in CFG or GAP SHALL return to IDLE next enabled cycle, no o_done; in SEND the current frame SHALL complete through its tlast transfer, then IDLE without o_done; abort in IDLE has no effect.
REQ-023 Simultaneous i_start and i_abort in IDLE: start SHALL win and abort is ignored.
REQ-024 tvalid SHALL never drop in SEND without a completed transfer.

Reset
REQ-025 While i_aresetn low: state IDLE, o_aclken 0 (1 when CLKDIV = 1), tvalid 0, tlast 0, tdata = {im seed, re seed}, cfg_tvalid 0, cfg_tdata 1, o_busy 0, o_done 0, o_frm_cnt 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately; no partial state survives.

Verification
REQ-027 CLKDIV=1, log2 4, pattern 0, mode 2, frm_num 3, gap 0, tready high -> 3 frames of 16 beats, first re 0x0001 im 0xFFFE, cfg_tdata 1,0,1, tlast on beat 15, o_done once, o_frm_cnt 3.
REQ-028 Random tready toggling, pattern 1, log2 3 -> tdata/tlast stable while stalled, re sequence 0..7, im 0xFFFF..0xFFF8.
REQ-029 log2_len 1 and 15 with MAX 12 -> frames of 8 and 4096 beats.
REQ-030 gap 5, CLKDIV 2 -> exactly 5 enabled cycles of tvalid low between tlast transfer and next cfg_tvalid.
REQ-031 Abort at beat 6 of frame 1 -> frame 1 completes, IDLE, o_done never pulses, o_frm_cnt 2.
REQ-032 Reset asserted in SEND, then restart -> all outputs at REQ-025 values, new run begins from frame 0 seed.

Source files
------------

// File: rtl/ipsxb_fft_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ipsxb_fft_pattern_gen_if
// Brief    : AXI4-Stream data and config channels between the FFT pattern
//            generator (master) and the FFT core (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ipsxb_fft_pattern_gen_if #(
  parameter int DW = 16
);
  logic            axi4s_data_tvalid;
  logic            axi4s_data_tready;
  logic [2*DW-1:0] axi4s_data_tdata;
  logic            axi4s_data_tlast;
  logic            axi4s_cfg_tvalid;
  logic            axi4s_cfg_tdata;

  modport master (
    output axi4s_data_tvalid, axi4s_data_tdata, axi4s_data_tlast,
    output axi4s_cfg_tvalid, axi4s_cfg_tdata,
    input  axi4s_data_tready
  );

  modport slave (
    input  axi4s_data_tvalid, axi4s_data_tdata, axi4s_data_tlast,
    input  axi4s_cfg_tvalid, axi4s_cfg_tdata,
    output axi4s_data_tready
  );
endinterface
`default_nettype wire

// File: rtl/ipsxb_fft_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ipsxb_fft_pattern_gen
// Brief    : Test-pattern source for an AXI4-Stream FFT core. Issues a
//            direction config beat per frame, then N complex samples drawn
//            from an LFSR, ramp, impulse or constant pattern, with an
//            optional idle gap between frames. All state advances on a
//            divided clock enable.
// Revision : 1.0 - initial release
// ============================================================================
module ipsxb_fft_pattern_gen #(
  parameter int CLKDIV        = 2,
  parameter int INPUT_WIDTH   = 16,
  parameter int MAX_LOG2_LEN  = 12,
  parameter int FRM_NUM_WIDTH = 8,
  parameter int GAP_WIDTH     = 8,
  localparam int DW = 8 * ((INPUT_WIDTH + 7) / 8),
  localparam int LW = $clog2(MAX_LOG2_LEN + 1)
) (
  input  wire logic                     i_aclk,
  input  wire logic                     i_aresetn,
  output logic                          o_aclken,
  input  wire logic                     i_start,
  input  wire logic                     i_abort,
  input  wire logic [LW-1:0]            i_log2_len,
  input  wire logic [1:0]               i_pattern,
  input  wire logic [1:0]               i_mode,
  input  wire logic [FRM_NUM_WIDTH-1:0] i_frm_num,
  input  wire logic [GAP_WIDTH-1:0]     i_gap,
  ipsxb_fft_pattern_gen_if.master       axi4s,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [FRM_NUM_WIDTH-1:0]      o_frm_cnt
);

  localparam int KW = MAX_LOG2_LEN;
  localparam logic [INPUT_WIDTH-1:0] RE_SEED  = INPUT_WIDTH'(1);
  localparam logic [INPUT_WIDTH-1:0] IM_SEED  = ~RE_SEED;
  localparam logic [INPUT_WIDTH-1:0] RE_CONST = INPUT_WIDTH'(1) << (INPUT_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG  = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            len_q, len_d;
  logic [1:0]               pattern_q, pattern_d;
  logic [1:0]               mode_q, mode_d;
  logic [FRM_NUM_WIDTH-1:0] frm_num_q, frm_num_d;
  logic [GAP_WIDTH-1:0]     gap_q, gap_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [FRM_NUM_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
  logic [KW-1:0]            k_q, k_d;
  logic [INPUT_WIDTH-1:0]   re_q, re_d;
  logic [INPUT_WIDTH-1:0]   im_q, im_d;
  logic                     dir_q, dir_d;
  logic                     abort_pend_q, abort_pend_d;

  logic                     w_en;
  logic [LW-1:0]            w_len_clamp;
  logic [KW:0]              w_n;
  logic [KW-1:0]            w_last_k;
  logic [FRM_NUM_WIDTH-1:0] w_frm_eff;
  logic                     w_tvalid;
  logic                     w_tlast;
  logic                     w_xfer;
  logic [INPUT_WIDTH-1:0]   w_re;
  logic [INPUT_WIDTH-1:0]   w_im;

  // Galois-free shift LFSR: shift left, feed back MSB xor LSB
  function automatic logic [INPUT_WIDTH-1:0] lfsr_next(input logic [INPUT_WIDTH-1:0] x);
    return {x[INPUT_WIDTH-2:0], x[INPUT_WIDTH-1] ^ x[0]};
  endfunction

  // Transform direction of a frame: 1 = forward FFT, 0 = inverse
  function automatic logic dir_of(input logic [1:0] m, input logic frm_lsb);
    case (m)
      2'd0:    return 1'b1;
      2'd1:    return 1'b0;
      default: return ~frm_lsb;
    endcase
  endfunction

  generate
    if (CLKDIV > 1) begin : g_div
      localparam int CW = $clog2(CLKDIV);
      logic [CW-1:0] div_q;

      // Free-running divider; enable fires on its terminal count
      always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn)                    div_q <= '0;
        else if (div_q == CW'(CLKDIV - 1)) div_q <= '0;
        else                               div_q <= div_q + 1'b1;
      end
      assign w_en = (div_q == CW'(CLKDIV - 1));
    end else begin : g_nodiv
      assign w_en = 1'b1;
    end
  endgenerate

  // Clamp the requested frame length into the supported range
  always_comb begin
    w_len_clamp = i_log2_len;
    if (i_log2_len < LW'(3))                 w_len_clamp = LW'(3);
    else if (i_log2_len > LW'(MAX_LOG2_LEN)) w_len_clamp = LW'(MAX_LOG2_LEN);
  end

  assign w_n       = (KW + 1)'(1) << len_q;
  assign w_last_k  = KW'(w_n - 1'b1);
  assign w_frm_eff = (frm_num_q == '0) ? FRM_NUM_WIDTH'(1) : frm_num_q;
  assign w_tvalid  = (state_q == S_SEND);
  assign w_tlast   = w_tvalid && (k_q == w_last_k);
  assign w_xfer    = w_tvalid && axi4s.axi4s_data_tready;

  // Sample generator: pick real/imag parts from the latched pattern
  always_comb begin
    w_re = re_q;
    w_im = im_q;
    case (pattern_q)
      2'd1: begin
        w_re = INPUT_WIDTH'(k_q);
        w_im = ~INPUT_WIDTH'(k_q);
      end
      2'd2: begin
        w_re = (k_q == '0) ? RE_SEED : '0;
        w_im = '0;
      end
      2'd3: begin
        w_re = RE_CONST;
        w_im = '0;
      end
      default: begin
        w_re = re_q;
        w_im = im_q;
      end
    endcase
  end

  // Control FSM next-state and datapath updates, gated by the clock enable
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pattern_d    = pattern_q;
    mode_d       = mode_q;
    frm_num_d    = frm_num_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    k_d          = k_q;
    re_d         = re_q;
    im_d         = im_q;
    dir_d        = dir_q;
    abort_pend_d = abort_pend_q;
    if (w_en) begin
      case (state_q)
        S_IDLE: begin
          // start has priority over a coincident abort
          if (i_start) begin
            state_d      = S_CFG;
            len_d        = w_len_clamp;
            pattern_d    = i_pattern;
            mode_d       = i_mode;
            frm_num_d    = i_frm_num;
            gap_d        = i_gap;
            frm_cnt_d    = '0;
            abort_pend_d = 1'b0;
            dir_d        = dir_of(i_mode, 1'b0);
          end
        end
        S_CFG: begin
          // every frame restarts from index 0 and the LFSR seeds
          k_d     = '0;
          re_d    = RE_SEED;
          im_d    = IM_SEED;
          state_d = i_abort ? S_IDLE : S_SEND;
        end
        S_SEND: begin
          if (i_abort) abort_pend_d = 1'b1;
          if (w_xfer) begin
            k_d  = k_q + 1'b1;
            re_d = lfsr_next(re_q);
            im_d = lfsr_next(im_q);
            if (w_tlast) begin
              frm_cnt_d = frm_cnt_q + 1'b1;
              if (abort_pend_q || i_abort) begin
                state_d = S_IDLE;
              end else if (frm_cnt_d == w_frm_eff) begin
                state_d = S_DONE;
              end else if (gap_q != '0) begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
              end else begin
                dir_d   = dir_of(mode_q, frm_cnt_d[0]);
                state_d = S_CFG;
              end
            end
          end
        end
        S_GAP: begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (i_abort) begin
            state_d = S_IDLE;
          end else if (gap_cnt_q == gap_q - 1'b1) begin
            dir_d   = dir_of(mode_q, frm_cnt_q[0]);
            state_d = S_CFG;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset leaves the LFSR seeds on the bus
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q      <= S_IDLE;
      len_q        <= LW'(3);
      pattern_q    <= 2'd0;
      mode_q       <= 2'd0;
      frm_num_q    <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      k_q          <= '0;
      re_q         <= RE_SEED;
      im_q         <= IM_SEED;
      dir_q        <= 1'b1;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      frm_num_q    <= frm_num_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      k_q          <= k_d;
      re_q         <= re_d;
      im_q         <= im_d;
      dir_q        <= dir_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign o_aclken                = w_en;
  assign axi4s.axi4s_data_tvalid = w_tvalid;
  assign axi4s.axi4s_data_tlast  = w_tlast;
  assign axi4s.axi4s_data_tdata  = {DW'($signed(w_im)), DW'($signed(w_re))};
  assign axi4s.axi4s_cfg_tvalid  = (state_q == S_CFG);
  assign axi4s.axi4s_cfg_tdata   = dir_q;
  assign o_busy                  = (state_q != S_IDLE);
  assign o_done                  = (state_q == S_DONE);
  assign o_frm_cnt               = frm_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsxb_fft_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipsxb_fft_pattern_gen
// Brief    : Directed self-checking bench for ipsxb_fft_pattern_gen
//            (CLKDIV=2, 16-bit samples, MAX_LOG2_LEN=12).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ipsxb_fft_pattern_gen;

  localparam int DW = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic [3:0] log2_len = 4'd4;
  logic [1:0] pattern  = 2'd0;
  logic [1:0] mode     = 2'd0;
  logic [7:0] frm_num  = 8'd1;
  logic [7:0] gap      = 8'd0;
  logic       aclken;
  logic       busy;
  logic       done;
  logic [7:0] frm_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // monitor state
  logic [32:0] q_beat[$];
  logic        q_cfg[$];
  int          q_gap[$];
  int          n_done   = 0;
  bit          in_gap   = 1'b0;
  int          gap_run  = 0;
  bit          hold_pend = 1'b0;
  logic [32:0] hold_val = '0;
  bit          mon_stab = 1'b0;

  ipsxb_fft_pattern_gen_if #(.DW(DW)) axi4s ();

  ipsxb_fft_pattern_gen #(
    .CLKDIV        (2),
    .INPUT_WIDTH   (16),
    .MAX_LOG2_LEN  (12),
    .FRM_NUM_WIDTH (8),
    .GAP_WIDTH     (8)
  ) dut (
    .i_aclk     (clk),
    .i_aresetn  (rst_n),
    .o_aclken   (aclken),
    .i_start    (start),
    .i_abort    (abort),
    .i_log2_len (log2_len),
    .i_pattern  (pattern),
    .i_mode     (mode),
    .i_frm_num  (frm_num),
    .i_gap      (gap),
    .axi4s      (axi4s),
    .o_busy     (busy),
    .o_done     (done),
    .o_frm_cnt  (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[0]};
  endfunction

  // Observe the bus just after each falling edge; inputs are stable then
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (mon_stab && hold_pend) begin
        chk_eq("stall_tvalid", axi4s.axi4s_data_tvalid, 1'b1);
        chk_eq("stall_hold", {axi4s.axi4s_data_tlast, axi4s.axi4s_data_tdata}, hold_val);
      end
      hold_pend = axi4s.axi4s_data_tvalid && !(aclken && axi4s.axi4s_data_tready);
      hold_val  = {axi4s.axi4s_data_tlast, axi4s.axi4s_data_tdata};
      if (aclken) begin
        if (axi4s.axi4s_data_tvalid && axi4s.axi4s_data_tready) begin
          q_beat.push_back({axi4s.axi4s_data_tlast, axi4s.axi4s_data_tdata});
          if (axi4s.axi4s_data_tlast) begin
            in_gap  = 1'b1;
            gap_run = 0;
          end
        end else if (axi4s.axi4s_cfg_tvalid) begin
          q_cfg.push_back(axi4s.axi4s_cfg_tdata);
          if (in_gap) begin
            q_gap.push_back(gap_run);
            in_gap = 1'b0;
          end
        end else if (in_gap && !axi4s.axi4s_data_tvalid) begin
          gap_run++;
        end
        if (done) n_done++;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic clear_mon();
    q_beat.delete();
    q_cfg.delete();
    q_gap.delete();
    n_done    = 0;
    in_gap    = 1'b0;
    gap_run   = 0;
    hold_pend = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_tvalid"}, axi4s.axi4s_data_tvalid, 1'b0);
    chk_eq({tag, "_tlast"}, axi4s.axi4s_data_tlast, 1'b0);
    chk_eq({tag, "_tdata"}, axi4s.axi4s_data_tdata, 32'hFFFE_0001);
    chk_eq({tag, "_cfg_tvalid"}, axi4s.axi4s_cfg_tvalid, 1'b0);
    chk_eq({tag, "_cfg_tdata"}, axi4s.axi4s_cfg_tdata, 1'b1);
    chk_eq({tag, "_busy"}, busy, 1'b0);
    chk_eq({tag, "_done"}, done, 1'b0);
    chk_eq({tag, "_frm_cnt"}, frm_cnt, 8'd0);
  endtask

  // Hold reset, check reset outputs, release and check the divider phase
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_aclken", aclken, 1'b0);
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("div_cycle1", aclken, 1'b0);
    @(negedge clk);
    chk_eq("div_cycle2", aclken, 1'b1);
    @(negedge clk);
    chk_eq("div_cycle3", aclken, 1'b0);
  endtask

  task automatic wait_en();
    @(negedge clk);
    while (!aclken) @(negedge clk);
  endtask

  task automatic start_run(input logic [3:0] l, input logic [1:0] p, input logic [1:0] m,
                           input logic [7:0] f, input logic [7:0] g, input bit ab);
    wait_en();
    log2_len = l;
    pattern  = p;
    mode     = m;
    frm_num  = f;
    gap      = g;
    start    = 1'b1;
    abort    = ab;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      if (rnd) axi4s.axi4s_data_tready = 1'($urandom_range(0, 1));
      n++;
    end
    axi4s.axi4s_data_tready = 1'b1;
    @(negedge clk);
    chk_eq("run_ends", busy, 1'b0);
  endtask

  initial begin
    logic [15:0] re, im;
    int          k, n;
    axi4s.axi4s_data_tready = 1'b1;

    do_reset();

    // A: LFSR, log2 4, alternating direction, 3 frames, no gap
    clear_mon();
    start_run(4'd4, 2'd0, 2'd2, 8'd3, 8'd0, 1'b0);
    wait_idle(3000, 1'b0);
    chk_eq("A_beats", q_beat.size(), 48);
    chk_eq("A_first", q_beat.size() > 0 ? q_beat[0] : 33'h0, {1'b0, 32'hFFFE_0001});
    chk_eq("A_second", q_beat.size() > 1 ? q_beat[1] : 33'h0, {1'b0, 32'hFFFD_0003});
    re = 16'h0001;
    im = 16'hFFFE;
    for (int b = 0; b < q_beat.size() && b < 48; b++) begin
      k = b % 16;
      if (k == 0) begin
        re = 16'h0001;
        im = 16'hFFFE;
      end
      chk_eq("A_beat", q_beat[b], {(k == 15), im, re});
      re = lfsr16(re);
      im = lfsr16(im);
    end
    chk_eq("A_cfg_n", q_cfg.size(), 3);
    for (int i = 0; i < q_cfg.size() && i < 3; i++)
      chk_eq("A_cfg_dir", q_cfg[i], (i % 2 == 0));
    chk_eq("A_gaps", q_gap.size(), 2);
    for (int i = 0; i < q_gap.size(); i++) chk_eq("A_gap_len", q_gap[i], 0);
    chk_eq("A_done", n_done, 1);
    chk_eq("A_frm_cnt", frm_cnt, 8'd3);

    // B: ramp, log2 3, random backpressure, bus must hold while stalled
    clear_mon();
    mon_stab = 1'b1;
    start_run(4'd3, 2'd1, 2'd0, 8'd1, 8'd0, 1'b0);
    wait_idle(4000, 1'b1);
    mon_stab = 1'b0;
    chk_eq("B_beats", q_beat.size(), 8);
    for (int b = 0; b < q_beat.size() && b < 8; b++) begin
      re = 16'(b);
      chk_eq("B_beat", q_beat[b], {(b == 7), ~re, re});
    end
    chk_eq("B_cfg_n", q_cfg.size(), 1);
    chk_eq("B_cfg_dir", q_cfg.size() > 0 ? q_cfg[0] : 1'b0, 1'b1);
    chk_eq("B_done", n_done, 1);

    // C1: log2 1 clamps up to 8 beats; impulse pattern
    clear_mon();
    start_run(4'd1, 2'd2, 2'd0, 8'd1, 8'd0, 1'b0);
    wait_idle(1000, 1'b0);
    chk_eq("C1_beats", q_beat.size(), 8);
    chk_eq("C1_beat0", q_beat.size() > 0 ? q_beat[0] : 33'h0, {1'b0, 32'h0000_0001});
    chk_eq("C1_beat1", q_beat.size() > 1 ? q_beat[1] : 33'h1, {1'b0, 32'h0000_0000});
    chk_eq("C1_beat7", q_beat.size() > 7 ? q_beat[7] : 33'h0, {1'b1, 32'h0000_0000});

    // C2: log2 15 clamps down to 4096 beats; constant; frm_num 0 means 1
    clear_mon();
    start_run(4'd15, 2'd3, 2'd0, 8'd0, 8'd0, 1'b0);
    wait_idle(12000, 1'b0);
    chk_eq("C2_beats", q_beat.size(), 4096);
    chk_eq("C2_beat0", q_beat.size() > 0 ? q_beat[0] : 33'h0, {1'b0, 32'h0000_4000});
    chk_eq("C2_beat4094", q_beat.size() > 4094 ? q_beat[4094] : 33'h0, {1'b0, 32'h0000_4000});
    chk_eq("C2_beat4095", q_beat.size() > 4095 ? q_beat[4095] : 33'h0, {1'b1, 32'h0000_4000});
    chk_eq("C2_done", n_done, 1);
    chk_eq("C2_frm_cnt", frm_cnt, 8'd1);

    // D: gap of 5 enabled cycles, inverse-only mode, 2 frames
    clear_mon();
    start_run(4'd3, 2'd3, 2'd1, 8'd2, 8'd5, 1'b0);
    wait_idle(1000, 1'b0);
    chk_eq("D_beats", q_beat.size(), 16);
    chk_eq("D_gaps", q_gap.size(), 1);
    chk_eq("D_gap_len", q_gap.size() > 0 ? q_gap[0] : -1, 5);
    chk_eq("D_cfg_n", q_cfg.size(), 2);
    for (int i = 0; i < q_cfg.size(); i++) chk_eq("D_cfg_dir", q_cfg[i], 1'b0);
    chk_eq("D_done", n_done, 1);
    chk_eq("D_frm_cnt", frm_cnt, 8'd2);

    // E: abort at beat 6 of frame 1 of a 3-frame run
    clear_mon();
    start_run(4'd4, 2'd0, 2'd2, 8'd3, 8'd2, 1'b0);
    n = 0;
    while (q_beat.size() < 22 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("E_reach_beat", q_beat.size() >= 22, 1'b1);
    wait_en();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(2000, 1'b0);
    chk_eq("E_beats", q_beat.size(), 32);
    chk_eq("E_last", q_beat.size() > 31 ? q_beat[31][32] : 1'b0, 1'b1);
    chk_eq("E_done", n_done, 0);
    chk_eq("E_frm_cnt", frm_cnt, 8'd2);
    chk_eq("E_cfg_n", q_cfg.size(), 2);

    // F: start and abort together in IDLE, start wins
    clear_mon();
    start_run(4'd3, 2'd2, 2'd0, 8'd1, 8'd0, 1'b1);
    wait_idle(1000, 1'b0);
    chk_eq("F_beats", q_beat.size(), 8);
    chk_eq("F_done", n_done, 1);

    // G: reset in SEND, then a fresh run starts from the seeds
    clear_mon();
    start_run(4'd4, 2'd0, 2'd0, 8'd2, 8'd0, 1'b0);
    n = 0;
    while (q_beat.size() < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("G_in_send", axi4s.axi4s_data_tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("G_rst");
    do_reset();
    clear_mon();
    start_run(4'd4, 2'd0, 2'd0, 8'd1, 8'd0, 1'b0);
    wait_idle(2000, 1'b0);
    chk_eq("G_beats", q_beat.size(), 16);
    chk_eq("G_first", q_beat.size() > 0 ? q_beat[0] : 33'h0, {1'b0, 32'hFFFE_0001});
    chk_eq("G_second", q_beat.size() > 1 ? q_beat[1] : 33'h0, {1'b0, 32'hFFFD_0003});
    chk_eq("G_done", n_done, 1);
    chk_eq("G_frm_cnt", frm_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
